// File: rtl/s21_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module      : s21_sweep_capture
// Description : Two-pass S21 frequency sweep; pass 1 finds the power peak,
//               pass 2 finds the first/last points at or above half power.
// Revision    : 1.0  initial release
// ============================================================================
module s21_sweep_capture #(
    parameter int STEPS  = 64,
    parameter int FW     = 32,
    parameter int MW     = 16,
    parameter int SETTLE = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_step,
    input  logic [MW-1:0] mag_in,
    input  logic          mag_valid,
    output logic [FW-1:0] f_word,
    output logic          f_load,
    output logic          busy,
    output logic          done,
    output logic [MW-1:0] peak_mag,
    output logic [7:0]    peak_idx,
    output logic [7:0]    lo_idx,
    output logic [7:0]    hi_idx
);

    localparam int            CW            = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] C_SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [7:0]    C_IDX_LAST    = 8'(STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_pass;
    logic [7:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [FW-1:0] r_fstart;
    logic [FW-1:0] r_fstep;
    logic [FW-1:0] r_fword;
    logic [MW-1:0] r_wpeak_mag;
    logic [7:0]    r_wpeak_idx;
    logic [7:0]    r_wlo;
    logic [7:0]    r_whi;
    logic          r_lo_found;
    logic          w_last;
    logic [MW-1:0] w_thr;

    assign w_last = (r_idx == C_IDX_LAST);
    // Pass 2 uses the peak found in pass 1 of this same sweep.
    assign w_thr  = r_wpeak_mag >> 1;
    assign f_word = r_fword;

    always_comb begin
        w_next_state = r_state;
        f_load       = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                f_load       = 1'b1;
                w_next_state = S_SETTLE;
            end
            S_SETTLE:  if (r_cnt == C_SETTLE_LAST) w_next_state = S_CAPTURE;
            S_CAPTURE: if (mag_valid) w_next_state = S_NEXT;
            S_NEXT:    w_next_state = (w_last && r_pass) ? S_DONE : S_LOAD;
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pass      <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_fstart    <= '0;
            r_fstep     <= '0;
            r_fword     <= '0;
            r_wpeak_mag <= '0;
            r_wpeak_idx <= '0;
            r_wlo       <= '0;
            r_whi       <= '0;
            r_lo_found  <= 1'b0;
            peak_mag    <= '0;
            peak_idx    <= '0;
            lo_idx      <= '0;
            hi_idx      <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: if (start) begin
                    r_fstart    <= f_start;
                    r_fstep     <= f_step;
                    r_fword     <= f_start;
                    r_idx       <= '0;
                    r_pass      <= 1'b0;
                    r_wpeak_mag <= '0;
                    r_wpeak_idx <= '0;
                    r_wlo       <= '0;
                    r_whi       <= '0;
                    r_lo_found  <= 1'b0;
                end
                S_LOAD:   r_cnt <= '0;
                S_SETTLE: r_cnt <= r_cnt + CW'(1);
                S_CAPTURE: if (mag_valid) begin
                    if (!r_pass) begin
                        // Strict compare keeps the lowest index on ties.
                        if (mag_in > r_wpeak_mag) begin
                            r_wpeak_mag <= mag_in;
                            r_wpeak_idx <= r_idx;
                        end
                    end else if (mag_in >= w_thr) begin
                        if (!r_lo_found) begin
                            r_wlo      <= r_idx;
                            r_lo_found <= 1'b1;
                        end
                        r_whi <= r_idx;
                    end
                end
                S_NEXT: begin
                    if (!w_last) begin
                        r_idx   <= r_idx + 8'd1;
                        r_fword <= r_fword + r_fstep;
                    end else if (!r_pass) begin
                        r_idx   <= '0;
                        r_pass  <= 1'b1;
                        r_fword <= r_fstart;
                    end else begin
                        peak_mag <= r_wpeak_mag;
                        peak_idx <= r_wpeak_idx;
                        lo_idx   <= r_wlo;
                        hi_idx   <= r_whi;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s21_sweep_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_s21_sweep_capture
// Description : Randomized self-checking bench for s21_sweep_capture.
// Revision    : 1.0  initial release
// ============================================================================
module tb_s21_sweep_capture;

    localparam int STEPS  = 8;
    localparam int FW     = 32;
    localparam int MW     = 16;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [FW-1:0] f_start = '0;
    logic [FW-1:0] f_step = '0;
    logic [MW-1:0] mag_in = '0;
    logic          mag_valid = 1'b0;
    logic [FW-1:0] f_word;
    logic          f_load;
    logic          busy;
    logic          done;
    logic [MW-1:0] peak_mag;
    logic [7:0]    peak_idx;
    logic [7:0]    lo_idx;
    logic [7:0]    hi_idx;

    s21_sweep_capture #(.STEPS(STEPS), .FW(FW), .MW(MW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .f_start(f_start), .f_step(f_step),
        .mag_in(mag_in), .mag_valid(mag_valid), .f_word(f_word), .f_load(f_load),
        .busy(busy), .done(done), .peak_mag(peak_mag), .peak_idx(peak_idx),
        .lo_idx(lo_idx), .hi_idx(hi_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int mags [STEPS];
    // Results the DUT should currently be presenting (last completed sweep).
    int held_peak = 0, held_pidx = 0, held_lo = 0, held_hi = 0;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag, input int pk, input int pi, input int lo, input int hi);
        check({tag, "_peak_mag"}, 64'(peak_mag), 64'(pk));
        check({tag, "_peak_idx"}, 64'(peak_idx), 64'(pi));
        check({tag, "_lo_idx"},   64'(lo_idx),   64'(lo));
        check({tag, "_hi_idx"},   64'(hi_idx),   64'(hi));
    endtask

    // One full sweep with mags[] presented in both passes. rst_pt >= 0 aborts
    // with a reset at that point of pass 2. poke_start pulses start mid-sweep.
    task automatic sweep(input string tag, input logic [FW-1:0] fs, input logic [FW-1:0] fst,
                         input int rst_pt, input bit poke_start);
        int pk, pi, thr, lo, hi, d0, t;
        logic [FW-1:0] exp_f;
        bit lo_found;
        pk = 0; pi = 0; lo = 0; hi = 0; lo_found = 0;
        for (int i = 0; i < STEPS; i++) if (mags[i] > pk) begin pk = mags[i]; pi = i; end
        thr = pk / 2;
        for (int i = 0; i < STEPS; i++) if (mags[i] >= thr) begin
            if (!lo_found) begin lo = i; lo_found = 1; end
            hi = i;
        end
        d0 = done_cnt;

        f_start = fs; f_step = fst; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < STEPS; i++) begin
                for (t = 0; t < 64 && !f_load; t++) @(negedge clk);
                if (!f_load) begin
                    check({tag, "_load_timeout"}, 64'(0), 64'(1));
                    return;
                end
                exp_f = fs + FW'(i) * fst;
                check({tag, "_f_word"}, 64'(f_word), 64'(exp_f));
                if (p == 0 && i == STEPS / 2)
                    check_results({tag, "_held"}, held_peak, held_pidx, held_lo, held_hi);
                if (p == 1 && i == rst_pt) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check({tag, "_rst_busy"},   64'(busy),   64'(0));
                    check({tag, "_rst_f_word"}, 64'(f_word), 64'(0));
                    check({tag, "_rst_f_load"}, 64'(f_load), 64'(0));
                    held_peak = 0; held_pidx = 0; held_lo = 0; held_hi = 0;
                    check_results({tag, "_rst"}, 0, 0, 0, 0);
                    repeat (3) @(negedge clk);
                    check({tag, "_rst_no_done"}, 64'(done_cnt - d0), 64'(0));
                    return;
                end
                // Decoy sample during LOAD/SETTLE that must never be captured.
                mag_valid = 1'b1; mag_in = 16'd999;
                if (poke_start && i == 2) start = 1'b1;
                repeat (1 + SETTLE) @(negedge clk);
                start = 1'b0;
                mag_valid = 1'b0; mag_in = MW'($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                mag_valid = 1'b1; mag_in = MW'(mags[i]);
                @(negedge clk);
                mag_valid = 1'b0;
            end
        end
        for (t = 0; t < 16 && !done; t++) @(negedge clk);
        check({tag, "_done_seen"}, 64'(done), 64'(1));
        check_results(tag, pk, pi, lo, hi);
        held_peak = pk; held_pidx = pi; held_lo = lo; held_hi = hi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_start_in_done_ignored"}, 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
        check({tag, "_one_done"}, 64'(done_cnt - d0), 64'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_f_load", 64'(f_load), 64'(0));
        check("reset_f_word", 64'(f_word), 64'(0));
        check_results("reset", 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        mags = '{1, 3, 9, 20, 12, 4, 2, 1};
        sweep("basic", 32'd1000, 32'd10, -1, 1'b0);

        mags = '{1, 3, 20, 9, 4, 20, 2, 1};
        sweep("tie", 32'd500, 32'd3, -1, 1'b0);

        mags = '{5, 5, 5, 5, 5, 5, 5, 5};
        sweep("wrap", 32'hFFFF_FFF6, 32'd7, -1, 1'b0);

        mags = '{0, 0, 0, 0, 0, 0, 0, 0};
        sweep("zeros_busy_start", 32'd42, 32'd1, -1, 1'b1);

        mags = '{2, 30, 7, 11, 40, 16, 3, 9};
        sweep("mid_reset", 32'd100, 32'd5, 3, 1'b0);
        sweep("after_reset", 32'd200, 32'd9, -1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < STEPS; i++) mags[i] = int'($urandom_range(0, 500));
            sweep("random", FW'($urandom), FW'($urandom), -1, 1'(r % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s21_sweep_capture.md
S21_SWEEP_CAPTURE -- requirements
Module: s21_sweep_capture

Interface
REQ-001 The block SHALL have parameter STEPS, default 64, meaning sweep points per pass (2..256).
REQ-002 The block SHALL have parameter FW, default 32, meaning frequency tuning word width.
REQ-003 The block SHALL have parameter MW, default 16, meaning linear power sample width.
REQ-004 The block SHALL have parameter SETTLE, default 8, meaning cycles discarded after each retune (>=1).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1, sweep request pulse.
REQ-008 The block SHALL have port f_start, input, FW, tuning word of point 0.
REQ-009 The block SHALL have port f_step, input, FW, tuning word increment per point.
REQ-010 The block SHALL have port mag_in, input, MW, detected S21 power sample.
REQ-011 The block SHALL have port mag_valid, input, 1, mag_in qualifier.
REQ-012 The block SHALL have port f_word, output, FW, tuning word to the port source.
REQ-013 The block SHALL have port f_load, output, 1, one-cycle strobe: apply f_word.
REQ-014 The block SHALL have port busy, output, 1, sweep in progress.
REQ-015 The block SHALL have port done, output, 1, one-cycle result-ready pulse.
REQ-016 The block SHALL have ports peak_mag (MW) and peak_idx (8), outputs, maximum power and its point index.
REQ-017 The block SHALL have ports lo_idx and hi_idx, outputs, 8 each, first/last index at or above half power.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, SETTLE, CAPTURE, NEXT, DONE; a pass flag selects pass 1 (peak) or pass 2 (edges).
REQ-019 IDLE: start=1 SHALL latch f_start/f_step, clear idx, set pass 1, go to LOAD; start while busy SHALL be ignored.
REQ-020 LOAD: f_word SHALL equal f_start + idx*f_step modulo 2^FW (wrap, no saturation); f_load=1 for exactly this cycle; next state SETTLE.
REQ-021 SETTLE: a counter SHALL run SETTLE cycles; mag_valid during LOAD/SETTLE SHALL be discarded; then CAPTURE.
REQ-022 CAPTURE: SHALL wait indefinitely; the first cycle with mag_valid=1 samples mag_in, then NEXT.
REQ-023 Pass 1 compare: sample > running peak (strict) SHALL update peak_mag/peak_idx; ties keep lowest index; running peak cleared to 0 at pass start, peak_idx to 0.
REQ-024 Pass 2 threshold SHALL be thr = peak_mag >> 1 (floor); first sample >= thr sets lo_idx, every sample >= thr sets hi_idx.
REQ-025 NEXT: idx < STEPS-1 SHALL increment idx and go to LOAD; idx = STEPS-1 in pass 1 SHALL clear idx, set pass 2, go to LOAD; in pass 2 go to DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-027 Result outputs SHALL update only at DONE entry and hold until the next DONE; internal working registers are separate.
REQ-028 peak_mag = 0 SHALL yield thr = 0, lo_idx = 0, hi_idx = STEPS-1.
REQ-029 Per-point latency SHALL be 1 (LOAD) + SETTLE + capture wait + 1 (NEXT) cycles; total sweep = 2*STEPS points.
REQ-030 start in DONE cycle SHALL be ignored; accepted from the following IDLE cycle.

Reset
REQ-031 rst=1 SHALL force IDLE at the next edge, overriding start, including mid-sweep.
REQ-032 Reset values SHALL be: f_word=0, f_load=0, busy=0, done=0, peak_mag=0, peak_idx=0, lo_idx=0, hi_idx=0, idx=0, counters=0.
REQ-033 Reset mid-sweep SHALL NOT emit done and SHALL discard partial results.

Verification
REQ-034 STEPS=8, SETTLE=2, f_start=1000, f_step=10, mags 1,3,9,20,12,4,2,1 both passes -> f_word 1000..1070, peak_mag=20, peak_idx=3, thr=10, lo_idx=3, hi_idx=4, one done pulse.
REQ-035 Equal maxima 20 at indices 2 and 5 -> peak_idx=2.
REQ-036 f_start=2^FW-10, f_step=7, STEPS=4 -> f_word = 2^FW-10, 2^FW-3, 4, 11.
REQ-037 mag_valid=1 held during LOAD/SETTLE with value 999, true capture value 5 -> 999 never sampled.
REQ-038 rst asserted at pass 2 point 3 -> next cycle busy=0, all outputs 0, no done; fresh start completes normally.
REQ-039 All samples 0 -> peak_mag=0, peak_idx=0, lo_idx=0, hi_idx=STEPS-1; start pulses while busy change nothing.
